// File: rtl/lsu_mem_initiator_if.sv
// lsu_mem_initiator_if: pipeline request/response handshake plus word-memory port
interface lsu_mem_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  MEM;
  logic [31:0] Addr;
  logic [31:0] Wdata;
  logic [31:0] Rdata;
  modport slave (
    input  req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, Rdata,
    output req_ready, resp_valid, resp_err, resp_rdata, MEM, Addr, Wdata
  );
  modport master (
    output req_valid, req_store, req_size, req_unsigned, req_addr, req_wdata, Rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, MEM, Addr, Wdata
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// lsu_mem_initiator: byte/half/word load-store initiator over a word-wide memory
module lsu_mem_initiator #(
  parameter int DEPTH_LOG2  = 10,
  parameter bit CHECK_RANGE = 1'b1
) (
  input logic clk,
  input logic rst_n,
  lsu_mem_initiator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;
  state_t state, state_nx;
  logic                  op_store, op_uns, err_r, accept, req_err;
  logic [1:0]            op_size;
  logic [DEPTH_LOG2+1:0] op_addr;
  logic [31:0]           wdata_r, rdata_r, lane_mask, lane_raw, load_val, merged;
  logic [4:0]            sh;
  assign accept  = state == IDLE && bus.req_valid;
  assign req_err = bus.req_size == 2'b11
                || (bus.req_size == 2'b01 && bus.req_addr[0])
                || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
                || (CHECK_RANGE && (bus.req_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
  // lane position, load extraction/extension and store merge from the sampled word
  always_comb begin
    sh        = op_size == 2'b00 ? {op_addr[1:0], 3'b000} : {op_addr[1], 4'b0000};
    lane_mask = (op_size == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    lane_raw  = (bus.Rdata & lane_mask) >> sh;
    load_val  = op_size == 2'b10 ? bus.Rdata
              : op_size == 2'b00 ? {{24{~op_uns & lane_raw[7]}}, lane_raw[7:0]}
              : {{16{~op_uns & lane_raw[15]}}, lane_raw[15:0]};
    merged    = (bus.Rdata & ~lane_mask) | ((wdata_r << sh) & lane_mask);
  end
  // next state: errors skip memory, sub-word stores read before writing
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (!bus.req_valid ? IDLE : req_err ? RESP
                                : (!bus.req_store || bus.req_size != 2'b10) ? RD : WR)
             : state == RD ? (op_store ? WR : RESP)
             : state == WR ? RESP : IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  // request latch, read-modify-write merge and load result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_store <= 1'b0;
      op_uns   <= 1'b0;
      op_size  <= 2'b00;
      op_addr  <= '0;
      wdata_r  <= '0;
      rdata_r  <= '0;
      err_r    <= 1'b0;
    end else if (accept) begin
      op_store <= bus.req_store;
      op_uns   <= bus.req_unsigned;
      op_size  <= bus.req_size;
      op_addr  <= bus.req_addr[DEPTH_LOG2+1:0];
      wdata_r  <= bus.req_wdata;
      rdata_r  <= '0;
      err_r    <= req_err;
    end else if (state == RD) begin
      if (op_store) wdata_r <= merged;
      else          rdata_r <= load_val;
    end
  end
  assign bus.req_ready  = state == IDLE;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_err   = err_r;
  assign bus.resp_rdata = rdata_r;
  assign bus.MEM        = {state == WR, state == RD};
  assign bus.Addr       = {{(30 - DEPTH_LOG2){1'b0}}, op_addr[DEPTH_LOG2+1:2]};
  assign bus.Wdata      = wdata_r;
endmodule
